// File: rtl/mode_ctrl_pkg.sv
// Shared widths, defaults and types for the mode/speed controller.
package mode_ctrl_pkg;

    localparam int unsigned MODE_W           = 4;
    localparam int unsigned SPEED_W          = 4;
    localparam int unsigned NUM_MODES        = 16;
    localparam int unsigned DEFAULT_DEBOUNCE = 500000;

    typedef logic [MODE_W-1:0]  mode_t;
    typedef logic [SPEED_W-1:0] speed_t;

    // Advance to the next mode, wrapping after the last one.
    function automatic mode_t next_mode(input mode_t m);
        return MODE_W'((32'(m) + 32'd1) % NUM_MODES);
    endfunction

endpackage

// File: rtl/debounce_bit.sv
// One raw asynchronous input: 2-flop synchronizer followed by a counting debouncer.
// level is the debounced value; fall pulses for one cycle when level goes 1->0.
module debounce_bit
    import mode_ctrl_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE,
    parameter int unsigned CNT_W           = 20,
    parameter logic        RST_VAL         = 1'b0
) (
    input  logic clkin,
    input  logic rst_n,
    input  logic raw,
    output logic level,
    output logic fall
);

    logic [1:0]       sync_q;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             level_q, level_d;
    logic             fall_q, fall_d;

    // Count consecutive cycles the synchronized input disagrees with level.
    always_comb begin
        cnt_d   = cnt_q;
        level_d = level_q;
        fall_d  = 1'b0;
        if (sync_q[1] == level_q) begin
            cnt_d = '0;
        end else if (cnt_q == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
            cnt_d   = '0;
            level_d = sync_q[1];
            fall_d  = level_q & ~sync_q[1];
        end else begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clkin or negedge rst_n) begin
        if (!rst_n) begin
            sync_q  <= {2{RST_VAL}};
            cnt_q   <= '0;
            level_q <= RST_VAL;
            fall_q  <= 1'b0;
        end else begin
            sync_q  <= {sync_q[0], raw};
            cnt_q   <= cnt_d;
            level_q <= level_d;
            fall_q  <= fall_d;
        end
    end

    assign level = level_q;
    assign fall  = fall_q;

endmodule

// File: rtl/mode_ctrl.sv
// Debounces switches (and optionally a push-button) into registered mode/speed.
// Define MODE_CTRL_KEY_EN to enable the key_n press-to-advance feature.
module mode_ctrl
    import mode_ctrl_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE,
    parameter int unsigned CNT_W           = 20
) (
    input  logic       clkin,
    input  logic       rst_n,
    input  logic [7:0] sw,
    input  logic       key_n,
    output mode_t      mode,
    output speed_t     speed,
    output logic       changed
);

    logic [7:0] sw_lvl;
    logic [7:0] sw_fall;
    logic       key_press;
    mode_t      sw_mode;
    speed_t     sw_speed;

    mode_t      mode_q, mode_d, mode_sw_q;
    speed_t     speed_q, speed_d;
    logic       changed_q, changed_d;

    for (genvar i = 0; i < 8; i++) begin : g_sw
        debounce_bit #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
            .CNT_W          (CNT_W),
            .RST_VAL        (1'b0)
        ) u_db (
            .clkin(clkin),
            .rst_n(rst_n),
            .raw  (sw[i]),
            .level(sw_lvl[i]),
            .fall (sw_fall[i])
        );
    end

    logic unused_sw_fall;
    assign unused_sw_fall = ^sw_fall;

`ifdef MODE_CTRL_KEY_EN
    logic key_lvl;
    logic unused_key_lvl;

    debounce_bit #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
        .CNT_W          (CNT_W),
        .RST_VAL        (1'b1)
    ) u_db_key (
        .clkin(clkin),
        .rst_n(rst_n),
        .raw  (key_n),
        .level(key_lvl),
        .fall (key_press)
    );
    assign unused_key_lvl = key_lvl;
`else
    logic unused_key_n;
    assign unused_key_n = key_n;
    assign key_press    = 1'b0;
`endif

    assign sw_mode  = mode_t'(sw_lvl[7:4]);
    assign sw_speed = speed_t'(sw_lvl[3:0]);

    // A debounced switch change outranks a key press landing in the same cycle.
    always_comb begin
        mode_d = mode_q;
        if (sw_mode != mode_sw_q) begin
            mode_d = sw_mode;
        end else if (key_press) begin
            mode_d = next_mode(mode_q);
        end
        speed_d   = sw_speed;
        changed_d = (mode_d != mode_q) || (speed_d != speed_q);
    end

    always_ff @(posedge clkin or negedge rst_n) begin
        if (!rst_n) begin
            mode_q    <= '0;
            mode_sw_q <= '0;
            speed_q   <= '0;
            changed_q <= 1'b0;
        end else begin
            mode_q    <= mode_d;
            mode_sw_q <= sw_mode;
            speed_q   <= speed_d;
            changed_q <= changed_d;
        end
    end

    assign mode    = mode_q;
    assign speed   = speed_q;
    assign changed = changed_q;

endmodule

// File: tb/tb_mode_ctrl.sv
// Self-checking bench for mode_ctrl with a short debounce; honours MODE_CTRL_KEY_EN.
module tb_mode_ctrl;

    localparam int unsigned D   = 4;
    localparam int unsigned CW  = 3;
`ifdef MODE_CTRL_KEY_EN
    localparam bit KEY_EN = 1'b1;
`else
    localparam bit KEY_EN = 1'b0;
`endif

    logic       clkin = 1'b0;
    logic       rst_n;
    logic [7:0] sw;
    logic       key_n;
    logic [3:0] mode;
    logic [3:0] speed;
    logic       changed;

    int checks   = 0;
    int failures = 0;

    mode_ctrl #(
        .DEBOUNCE_CYCLES(D),
        .CNT_W          (CW)
    ) dut (
        .clkin  (clkin),
        .rst_n  (rst_n),
        .sw     (sw),
        .key_n  (key_n),
        .mode   (mode),
        .speed  (speed),
        .changed(changed)
    );

    always #5 clkin = ~clkin;

    // Reference model: a debounced bit flips once the last D synchronized
    // samples (raw delayed two clocks) all disagree with it; outputs follow a clock later.
    logic [8:0] hist [0:D+1];
    logic [8:0] lvl;
    logic [3:0] lvl_mode_prev;
    logic       key_lvl_prev;
    logic [3:0] m_mode, m_speed, nm, ns;
    logic       m_changed;
    logic       flip;

    always @(posedge clkin or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i <= D + 1; i++) hist[i] = 9'h100;
            lvl           = 9'h100;
            lvl_mode_prev = 4'd0;
            key_lvl_prev  = 1'b1;
            m_mode        = 4'd0;
            m_speed       = 4'd0;
            m_changed     = 1'b0;
        end else begin
            nm = m_mode;
            if (lvl[7:4] != lvl_mode_prev) nm = lvl[7:4];
            else if (KEY_EN && key_lvl_prev && !lvl[8]) nm = m_mode + 4'd1;
            ns = lvl[3:0];
            m_changed     = (nm != m_mode) || (ns != m_speed);
            m_mode        = nm;
            m_speed       = ns;
            lvl_mode_prev = lvl[7:4];
            key_lvl_prev  = lvl[8];
            for (int i = D + 1; i >= 1; i--) hist[i] = hist[i-1];
            hist[0] = {key_n, sw};
            for (int b = 0; b < 9; b++) begin
                flip = 1'b1;
                for (int i = 2; i <= D + 1; i++) if (hist[i][b] == lvl[b]) flip = 1'b0;
                if (flip) lvl[b] = ~lvl[b];
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    task automatic test_reset();
        rst_n = 1'b0; sw = 8'h00; key_n = 1'b1;
        repeat (3) @(negedge clkin);
        checks++;
        if (mode !== 4'd0 || speed !== 4'd0 || changed !== 1'b0) begin
            failures++;
            $display("FAIL reset_state: mode=%0d speed=%0d changed=%b, required 0 0 0", mode, speed, changed);
        end
        rst_n = 1'b1;
        repeat (2) @(negedge clkin);
        checks++;
        if (mode !== 4'd0 || speed !== 4'd0 || changed !== 1'b0) begin
            failures++;
            $display("FAIL post_reset_idle: mode=%0d speed=%0d changed=%b, required 0 0 0", mode, speed, changed);
        end
    endtask

    task automatic test_latency();
        logic [3:0] em, es;
        logic       ec;
        sw = 8'h3A;
        for (int i = 1; i <= 9; i++) begin
            @(negedge clkin);
            em = (i >= 7) ? 4'd3  : 4'd0;
            es = (i >= 7) ? 4'd10 : 4'd0;
            ec = (i == 7);
            checks++;
            if (mode !== em || speed !== es || changed !== ec) begin
                failures++;
                $display("FAIL latency_c%0d: mode=%0d speed=%0d changed=%b, required %0d %0d %b", i, mode, speed, changed, em, es, ec);
            end
        end
    endtask

    task automatic test_glitch();
        int pulses = 0;
        sw = 8'h3B;
        for (int i = 1; i <= 12; i++) begin
            @(negedge clkin);
            if (i == 3) sw = 8'h3A;
            if (changed === 1'b1) pulses++;
            checks++;
            if (mode !== 4'd3 || speed !== 4'd10) begin
                failures++;
                $display("FAIL glitch_c%0d: mode=%0d speed=%0d, required 3 10", i, mode, speed);
            end
        end
        checks++;
        if (pulses != 0) begin
            failures++;
            $display("FAIL glitch_changed: pulses=%0d, required 0", pulses);
        end
    endtask

`ifdef MODE_CTRL_KEY_EN
    task automatic test_key_wrap();
        int pulses = 0;
        sw = 8'hF0;
        repeat (9) @(negedge clkin);
        checks++;
        if (mode !== 4'd15 || speed !== 4'd0) begin
            failures++;
            $display("FAIL key_wrap_setup: mode=%0d speed=%0d, required 15 0", mode, speed);
        end
        key_n = 1'b0;
        for (int i = 1; i <= 22; i++) begin
            @(negedge clkin);
            if (i == 10) key_n = 1'b1;
            if (changed === 1'b1) pulses++;
            if (i == 7) begin
                checks++;
                if (mode !== 4'd0 || changed !== 1'b1) begin
                    failures++;
                    $display("FAIL key_wrap_edge: mode=%0d changed=%b, required 0 1", mode, changed);
                end
            end
        end
        checks++;
        if (pulses != 1 || mode !== 4'd0) begin
            failures++;
            $display("FAIL key_wrap_once: pulses=%0d mode=%0d, required 1 0", pulses, mode);
        end
    endtask

    task automatic test_key_vs_switch();
        int pulses = 0;
        sw = 8'h20;
        repeat (9) @(negedge clkin);
        checks++;
        if (mode !== 4'd2) begin
            failures++;
            $display("FAIL key_vs_sw_setup: mode=%0d, required 2", mode);
        end
        sw = 8'h50; key_n = 1'b0;
        for (int i = 1; i <= 12; i++) begin
            @(negedge clkin);
            if (changed === 1'b1) pulses++;
            if (i == 7) begin
                checks++;
                if (mode !== 4'd5 || changed !== 1'b1) begin
                    failures++;
                    $display("FAIL key_vs_sw_edge: mode=%0d changed=%b, required 5 1", mode, changed);
                end
            end
        end
        checks++;
        if (pulses != 1 || mode !== 4'd5) begin
            failures++;
            $display("FAIL key_vs_sw_once: pulses=%0d mode=%0d, required 1 5", pulses, mode);
        end
        key_n = 1'b1;
        repeat (9) @(negedge clkin);
    endtask
`else
    task automatic test_key_ignored();
        int pulses = 0;
        for (int t = 0; t < 5; t++) begin
            key_n = ~key_n;
            for (int i = 0; i < 10; i++) begin
                @(negedge clkin);
                if (changed === 1'b1) pulses++;
            end
            checks++;
            if (mode !== 4'd3) begin
                failures++;
                $display("FAIL key_ignored_t%0d: mode=%0d, required 3", t, mode);
            end
        end
        checks++;
        if (pulses != 0) begin
            failures++;
            $display("FAIL key_ignored_changed: pulses=%0d, required 0", pulses);
        end
        key_n = 1'b1;
        repeat (9) @(negedge clkin);
    endtask
`endif

    task automatic test_reset_mid();
        logic [3:0] e;
        logic       ec;
        rst_n = 1'b0; sw = 8'h00; key_n = 1'b1;
        repeat (2) @(negedge clkin);
        rst_n = 1'b1;
        repeat (2) @(negedge clkin);
        sw = 8'hFF;
        repeat (2) @(negedge clkin);
        rst_n = 1'b0;
        #1;
        checks++;
        if (mode !== 4'd0 || speed !== 4'd0 || changed !== 1'b0) begin
            failures++;
            $display("FAIL reset_mid_async: mode=%0d speed=%0d changed=%b, required 0 0 0", mode, speed, changed);
        end
        for (int i = 0; i < 3; i++) begin
            @(negedge clkin);
            checks++;
            if (mode !== 4'd0 || speed !== 4'd0 || changed !== 1'b0) begin
                failures++;
                $display("FAIL reset_mid_hold%0d: mode=%0d speed=%0d changed=%b, required 0 0 0", i, mode, speed, changed);
            end
        end
        rst_n = 1'b1;
        for (int i = 1; i <= 9; i++) begin
            @(negedge clkin);
            e  = (i >= 7) ? 4'd15 : 4'd0;
            ec = (i == 7);
            checks++;
            if (mode !== e || speed !== e || changed !== ec) begin
                failures++;
                $display("FAIL reset_mid_c%0d: mode=%0d speed=%0d changed=%b, required %0d %0d %b", i, mode, speed, changed, e, e, ec);
            end
        end
    endtask

    task automatic test_random();
        int hold;
        int errs = 0;
        for (int n = 0; n < 60; n++) begin
            sw = sw ^ 8'($urandom_range(0, 255));
            if ($urandom_range(0, 2) == 0) key_n = ~key_n;
            hold = $urandom_range(1, 2 * D + 3);
            for (int i = 0; i < hold; i++) begin
                @(negedge clkin);
                checks++;
                if (mode !== m_mode || speed !== m_speed || changed !== m_changed) begin
                    failures++;
                    errs++;
                    if (errs <= 10)
                        $display("FAIL random_model t=%0t: mode=%0d speed=%0d changed=%b, required %0d %0d %b", $time, mode, speed, changed, m_mode, m_speed, m_changed);
                end
            end
        end
        repeat (3 * D) @(negedge clkin);
        checks++;
        if (mode !== m_mode || speed !== m_speed || changed !== m_changed) begin
            failures++;
            $display("FAIL random_settle: mode=%0d speed=%0d changed=%b, required %0d %0d %b", mode, speed, changed, m_mode, m_speed, m_changed);
        end
    endtask

    initial begin
        test_reset();
        test_latency();
        test_glitch();
`ifdef MODE_CTRL_KEY_EN
        test_key_wrap();
        test_key_vs_switch();
`else
        test_key_ignored();
`endif
        test_reset_mid();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
